// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Upstream ready and downstream valid are flops; flush squashes all held entries.
module if_id_skid_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               freez,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    main_pc_reg, main_pc_next;
    logic [INSTR_W-1:0] main_instr_reg, main_instr_next;
    logic [PC_W-1:0]    skid_pc_reg, skid_pc_next;
    logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [CNT_W-1:0]   stall_count_reg;
    logic               accept;
    logic               deliver;

    assign accept  = in_valid && in_ready_reg;
    assign deliver = out_valid_reg && out_ready;

    always_comb begin
        state_next      = state_reg;
        main_pc_next    = main_pc_reg;
        main_instr_next = main_instr_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;
        if (flush) begin
            // Squash wins over any handshake happening in the same cycle.
            state_next      = EMPTY;
            main_pc_next    = '0;
            main_instr_next = '0;
            skid_pc_next    = '0;
            skid_instr_next = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_pc_next    = in_pc;
                        main_instr_next = in_instr;
                        state_next      = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_pc_next    = in_pc;
                        main_instr_next = in_instr;
                    end else if (accept) begin
                        skid_pc_next    = in_pc;
                        skid_instr_next = in_instr;
                        state_next      = FULL;
                    end else if (deliver) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_pc_next    = skid_pc_reg;
                        main_instr_next = skid_instr_reg;
                        state_next      = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= EMPTY;
            main_pc_reg     <= '0;
            main_instr_reg  <= '0;
            skid_pc_reg     <= '0;
            skid_instr_reg  <= '0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            main_pc_reg    <= main_pc_next;
            main_instr_reg <= main_instr_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
            // Handshake flags are registered copies of the next-state decode.
            in_ready_reg   <= (state_next != FULL);
            out_valid_reg  <= (state_next != EMPTY);
            if (out_valid_reg && !out_ready && (stall_count_reg != {CNT_W{1'b1}}))
                stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

    assign in_ready    = in_ready_reg;
    assign freez       = !in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_pc      = main_pc_reg;
    assign out_instr   = main_instr_reg;
    assign stall_count = stall_count_reg;

endmodule
